arith_operator_core: RTL and testbench
======================================

# arith_operator_core

Registered three-way arithmetic core for 16-bit operands. Each accepted operand pair is evaluated in parallel as:

- a signed Q8.8 fixed-point sum;
- a signed Q8.8 fixed-point product;
- a half-precision-style floating-point sum (1 sign, 5 exponent, 10 fraction bits).

All three results and their overflow flags are registered together. The core sits behind the operand-entry/display logic of the calculator datapath and feeds the result-select mux.

## Interface

Parameters: none; all widths are fixed at 16 bits.

Reset is asynchronous and active-low. There is one clock.

- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  when high, num1/num2 are sampled this cycle.
- num1  input  16  operand A.
- num2  input  16  operand B.
- fix_sum  output  16  Q8.8 sum.
- fix_prod  output  16  Q8.8 product.
- flo_sum  output  16  float sum.
- overflow  output  3  bit 0 = fixed add, bit 1 = fixed multiply, bit 2 = float add.
- out_valid  output  1  high for one cycle after each accepted operand pair.

## Operation

**Fixed formats.** Operands are two's-complement signed Q8.8: bits 15:8 are the integer part, bits 7:0 the fraction.

**Fixed add.**
- fix_sum = (num1 + num2) mod 2^16, i.e. the result wraps.
- overflow[0] = 1 when both operands have the same sign and the result sign differs.

**Fixed multiply.**
- Form the full signed 32-bit product.
- fix_prod = product[23:8]. This is an arithmetic truncation, i.e. rounding toward −∞.
- overflow[1] = 1 when product[31:23] is not all-equal, i.e. the result does not fit signed Q8.8.

**Float format.** Fields are sign = bit 15, exp = bits 14:10, frac = bits 9:0, with bias 15 and an implicit leading 1.
- exp = 0 is flushed to zero; there are no subnormals.
- exp = 31 is treated as an out-of-range input.

**Float add.**
- If either input has exp = 31: flo_sum = {sign of the larger-magnitude input, 5'b11111, 10'b0} and overflow[2] = 1.
- Otherwise the steps are:
  - Zero-flush inputs with exp = 0.
  - Order the operands by magnitude.
  - Right-shift the smaller significand by the exponent difference, truncating. A shift of 11 or more makes it zero.
  - Add the significands if the signs match, otherwise subtract.
  - Normalize:
    - On a carry out, shift right by 1 and increment the exponent (truncating).
    - On cancellation, shift left until the leading 1 is in place, decrementing the exponent.
  - The result sign is the sign of the larger-magnitude operand.
  - An exactly zero result is +0 (0x0000).
  - If the exponent would fall to ≤ 0, the result is +0 and overflow[2] = 0.
  - If the exponent reaches 31, flo_sum = {sign, 5'b11111, 10'b0} and overflow[2] = 1.
- No rounding is performed; all discarded bits are truncated.

**Register stage.**
- The combinational results are captured into the output registers when in_valid = 1.
- When in_valid = 0, the outputs hold their previous values.

## Timing

- Latency is 1 cycle. Operands sampled at rising edge N appear on the outputs immediately after edge N, and out_valid is high for the cycle following edge N.
- out_valid is a registered copy of in_valid. Back-to-back valid inputs give full throughput, one result per cycle.
- Reset: while rst_n = 0, fix_sum, fix_prod, flo_sum, overflow and out_valid are all 0, independent of clk.
- Reset released mid-stream: the first accepted pair is the one with in_valid = 1 at the first rising edge after rst_n goes high.
- Reset asserted mid-operation: the result in flight is discarded, and out_valid = 0 immediately.
- The overflow bits are per-operation and registered alongside their results. There is no sticky state.

## Test plan

- **Reset:** assert rst_n = 0 with nonzero operands → all outputs are 0 and out_valid = 0. Release reset, apply num1 = 0x001B, num2 = 0x002A with in_valid = 1 → next cycle:
  - fix_sum = 0x0045 and fix_prod = 0x0004;
  - flo_sum = 0x0000, because both inputs are subnormal and flush to zero;
  - overflow = 3'b000 and out_valid = 1.
- **Fixed signed and overflow cases:**
  - 0xFE00 × 0x0180 → fix_prod = 0xFD00 (−3.0), overflow[1] = 0.
  - 0x7F00 + 0x0100 → fix_sum = 0x8000, overflow[0] = 1.
  - 0x1000 × 0x1000 → fix_prod = 0x0000, overflow[1] = 1.
- **Float add, basic:**
  - 0x3C00 + 0x3E00 → 0x4100 (2.5).
  - 0x3E00 + 0xBC00 → 0x3800 (0.5).
  - 0x3C00 + 0xBC00 → 0x0000.
  - overflow[2] = 0 in all three.
- **Float add overflow:** 0x7BFF + 0x7BFF → flo_sum = 0x7C00, overflow[2] = 1. 0x7C00 + 0x3C00 → flo_sum = 0x7C00, overflow[2] = 1.
- **Float alignment:** 0x6400 (1024) + 0x3C00 (1) → 0x6401. 0x6800 (2048) + 0x3C00 → 0x6800, the smaller addend is fully truncated.
- **Handshake:** apply 3 back-to-back valid pairs, then hold in_valid = 0 for 2 cycles → 3 consecutive out_valid pulses with matching results, after which the outputs hold the third result. Pulse rst_n low mid-burst → outputs clear immediately.

Source files
------------

// File: rtl/arith_operator_core_if.sv
// arith_operator_core_if
//   Operand/result bundle for arith_operator_core.
//   master: drives in_valid/num1/num2, observes results (operand-entry side).
//   slave : the arithmetic core.
//   Signals:
//     in_valid  operands present this cycle
//     num1/num2 16-bit operands (Q8.8 or half-float bit patterns)
//     fix_sum   Q8.8 sum           fix_prod  Q8.8 product
//     flo_sum   half-float sum     overflow  {float add, fixed mul, fixed add}
//     out_valid result registers were loaded on the last edge
interface arith_operator_core_if;
    logic        in_valid;
    logic [15:0] num1;
    logic [15:0] num2;
    logic [15:0] fix_sum;
    logic [15:0] fix_prod;
    logic [15:0] flo_sum;
    logic [2:0]  overflow;
    logic        out_valid;

    modport master (
        output in_valid, num1, num2,
        input  fix_sum, fix_prod, flo_sum, overflow, out_valid
    );

    modport slave (
        input  in_valid, num1, num2,
        output fix_sum, fix_prod, flo_sum, overflow, out_valid
    );
endinterface

// File: rtl/arith_operator_core.sv
// arith_operator_core
//   One-cycle registered arithmetic on a 16-bit operand pair, three ways in
//   parallel: Q8.8 add (wrapping), Q8.8 multiply (floor-truncated) and a
//   half-precision-style float add (flush-to-zero, truncating, exp 31 is
//   treated as out-of-range).
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset, clears all outputs
//     bus    arith_operator_core_if.slave (operands in, results out)
module arith_operator_core (
    input  logic                  clk,
    input  logic                  rst_n,
    arith_operator_core_if.slave  bus
);
    localparam int STAGES = 1;

    // ---------------- fixed point ----------------
    logic [15:0]        add_sum;
    logic               add_ovf;
    logic signed [31:0] prod;
    logic               mul_ovf;

    assign add_sum = bus.num1 + bus.num2;
    // Same-sign operands producing an opposite-sign result.
    assign add_ovf = (bus.num1[15] == bus.num2[15]) && (add_sum[15] != bus.num1[15]);

    assign prod    = $signed(bus.num1) * $signed(bus.num2);
    // Result fits Q8.8 only if bits 31:23 are a pure sign extension.
    assign mul_ovf = !((&prod[31:23]) || (~|prod[31:23]));

    // ---------------- float add ----------------
    logic [4:0]  ea, eb;
    logic [14:0] mag_a, mag_b;   // magnitude after zero-flush
    logic [10:0] ma, mb;         // significands with implicit 1
    logic        a_big;

    assign ea    = bus.num1[14:10];
    assign eb    = bus.num2[14:10];
    assign mag_a = (ea == 5'd0) ? 15'd0 : bus.num1[14:0];
    assign mag_b = (eb == 5'd0) ? 15'd0 : bus.num2[14:0];
    assign ma    = (ea == 5'd0) ? 11'd0 : {1'b1, bus.num1[9:0]};
    assign mb    = (eb == 5'd0) ? 11'd0 : {1'b1, bus.num2[9:0]};
    assign a_big = (mag_a >= mag_b);

    logic              big_s;
    logic [4:0]        big_e, sml_e, exp_diff;
    logic [10:0]       big_m, sml_m, sml_sh;
    logic [11:0]       sig_sum;
    logic [3:0]        lz;
    logic [10:0]       norm_m;
    logic signed [6:0] norm_e;
    logic [15:0]       flo_res;
    logic              flo_ovf;

    always_comb begin
        big_s    = a_big ? bus.num1[15] : bus.num2[15];
        big_e    = a_big ? ea : eb;
        big_m    = a_big ? ma : mb;
        sml_e    = a_big ? eb : ea;
        sml_m    = a_big ? mb : ma;
        // Magnitude ordering guarantees big_e >= sml_e.
        exp_diff = big_e - sml_e;
        sml_sh   = (exp_diff >= 5'd11) ? 11'd0 : (sml_m >> exp_diff);

        if (bus.num1[15] == bus.num2[15])
            sig_sum = {1'b0, big_m} + {1'b0, sml_sh};
        else
            sig_sum = {1'b0, big_m} - {1'b0, sml_sh};

        // Left-shift amount to bring the leading 1 to bit 10.
        lz = 4'd0;
        for (int i = 0; i < 11; i++)
            if (sig_sum[i]) lz = 4'(10 - i);

        if (sig_sum[11]) begin
            norm_m = sig_sum[11:1];
            norm_e = $signed({2'b00, big_e}) + 7'sd1;
        end else begin
            norm_m = sig_sum[10:0] << lz;
            norm_e = $signed({2'b00, big_e}) - $signed({3'b000, lz});
        end

        flo_res = 16'h0000;
        flo_ovf = 1'b0;
        if (ea == 5'd31 || eb == 5'd31) begin
            flo_res = {big_s, 5'h1f, 10'h000};
            flo_ovf = 1'b1;
        end else if (sig_sum == 12'd0 || norm_e <= 7'sd0) begin
            flo_res = 16'h0000;
        end else if (norm_e >= 7'sd31) begin
            flo_res = {big_s, 5'h1f, 10'h000};
            flo_ovf = 1'b1;
        end else begin
            flo_res = {big_s, norm_e[4:0], norm_m[9:0]};
        end
    end

    // ---------------- result register ----------------
    logic [STAGES:0] vld_pipe;
    assign vld_pipe[0] = bus.in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe[STAGES:1] <= '0;
            bus.fix_sum        <= '0;
            bus.fix_prod       <= '0;
            bus.flo_sum        <= '0;
            bus.overflow       <= '0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            if (bus.in_valid) begin
                bus.fix_sum  <= add_sum;
                bus.fix_prod <= prod[23:8];
                bus.flo_sum  <= flo_res;
                bus.overflow <= {flo_ovf, mul_ovf, add_ovf};
            end
        end
    end

    assign bus.out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_arith_operator_core.sv
module tb_arith_operator_core;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    arith_operator_core_if bus ();

    arith_operator_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [15:0] fs;
        logic [15:0] fp;
        logic [15:0] fl;
        logic [2:0]  ovf;
    } res_t;

    typedef struct {
        logic [15:0] n1;
        logic [15:0] n2;
        int          sel;   // 0 fix_sum, 1 fix_prod, 2 flo_sum, 3..5 overflow bit (sel-3)
        logic [15:0] want;
        string       name;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // Float add reference, done on integer significands/exponents.
    function automatic logic [16:0] ref_flo(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, maga, magb, e_big, e_sml, m_big, m_sml, d, s, e;
        logic s_big;
        ea   = int'(a[14:10]);
        eb   = int'(b[14:10]);
        maga = (ea == 0) ? 0 : int'(a[14:0]);
        magb = (eb == 0) ? 0 : int'(b[14:0]);
        if (maga >= magb) begin
            s_big = a[15]; e_big = ea; e_sml = eb;
            m_big = (ea == 0) ? 0 : 1024 + int'(a[9:0]);
            m_sml = (eb == 0) ? 0 : 1024 + int'(b[9:0]);
        end else begin
            s_big = b[15]; e_big = eb; e_sml = ea;
            m_big = (eb == 0) ? 0 : 1024 + int'(b[9:0]);
            m_sml = (ea == 0) ? 0 : 1024 + int'(a[9:0]);
        end
        if (ea == 31 || eb == 31) return {1'b1, s_big, 5'h1f, 10'h000};
        d = e_big - e_sml;
        m_sml = (d >= 11) ? 0 : (m_sml >> d);
        s = (a[15] == b[15]) ? m_big + m_sml : m_big - m_sml;
        e = e_big;
        if (s == 0) return 17'h0;
        while (s >= 2048) begin s = s / 2; e++; end
        while (s < 1024)  begin s = s * 2; e--; end
        if (e <= 0) return 17'h0;
        if (e >= 31) return {1'b1, s_big, 5'h1f, 10'h000};
        return {1'b0, s_big, 5'(e), 10'(s)};
    endfunction

    function automatic res_t model(input logic [15:0] a, input logic [15:0] b);
        res_t r;
        int sa, sb, s, p, q;
        logic [16:0] f;
        sa = int'($signed(a));
        sb = int'($signed(b));
        s  = sa + sb;
        p  = sa * sb;
        q  = p >>> 8;
        f  = ref_flo(a, b);
        r.fs  = 16'(s);
        r.fp  = 16'(q);
        r.fl  = f[15:0];
        r.ovf = {f[16], (q > 32767 || q < -32768), (s > 32767 || s < -32768)};
        return r;
    endfunction

    task automatic check_all(input string nm, input res_t ex);
        check({nm, ".fix_sum"},  {16'h0, bus.fix_sum},  {16'h0, ex.fs});
        check({nm, ".fix_prod"}, {16'h0, bus.fix_prod}, {16'h0, ex.fp});
        check({nm, ".flo_sum"},  {16'h0, bus.flo_sum},  {16'h0, ex.fl});
        check({nm, ".overflow"}, {29'h0, bus.overflow}, {29'h0, ex.ovf});
    endtask

    // One valid cycle, then idle; returns with outputs settled after the edge.
    task automatic apply(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.num1 = a; bus.num2 = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    vec_t vecs[$];
    res_t ex;
    logic [15:0] act;
    logic [15:0] a, b;
    logic [15:0] hs_a[3];
    logic [15:0] hs_b[3];
    logic v;

    initial begin
        vecs.push_back('{16'hFE00, 16'h0180, 1, 16'hFD00, "mul_neg"});
        vecs.push_back('{16'hFE00, 16'h0180, 4, 16'h0000, "mul_neg_ovf"});
        vecs.push_back('{16'h7F00, 16'h0100, 0, 16'h8000, "add_wrap"});
        vecs.push_back('{16'h7F00, 16'h0100, 3, 16'h0001, "add_wrap_ovf"});
        vecs.push_back('{16'h1000, 16'h1000, 1, 16'h0000, "mul_big"});
        vecs.push_back('{16'h1000, 16'h1000, 4, 16'h0001, "mul_big_ovf"});
        vecs.push_back('{16'h3C00, 16'h3E00, 2, 16'h4100, "fadd_2p5"});
        vecs.push_back('{16'h3C00, 16'h3E00, 5, 16'h0000, "fadd_2p5_ovf"});
        vecs.push_back('{16'h3E00, 16'hBC00, 2, 16'h3800, "fsub_0p5"});
        vecs.push_back('{16'h3E00, 16'hBC00, 5, 16'h0000, "fsub_0p5_ovf"});
        vecs.push_back('{16'h3C00, 16'hBC00, 2, 16'h0000, "fsub_zero"});
        vecs.push_back('{16'h3C00, 16'hBC00, 5, 16'h0000, "fsub_zero_ovf"});
        vecs.push_back('{16'h7BFF, 16'h7BFF, 2, 16'h7C00, "fadd_huge"});
        vecs.push_back('{16'h7BFF, 16'h7BFF, 5, 16'h0001, "fadd_huge_ovf"});
        vecs.push_back('{16'h7C00, 16'h3C00, 2, 16'h7C00, "fadd_inf_in"});
        vecs.push_back('{16'h7C00, 16'h3C00, 5, 16'h0001, "fadd_inf_in_ovf"});
        vecs.push_back('{16'h6400, 16'h3C00, 2, 16'h6401, "fadd_align10"});
        vecs.push_back('{16'h6800, 16'h3C00, 2, 16'h6800, "fadd_align11"});

        // Reset with live operands: everything stays zero.
        bus.in_valid = 1'b1; bus.num1 = 16'h1234; bus.num2 = 16'h5678;
        repeat (3) @(posedge clk);
        #1;
        check("rst.fix_sum",   {16'h0, bus.fix_sum},  32'h0);
        check("rst.fix_prod",  {16'h0, bus.fix_prod}, 32'h0);
        check("rst.flo_sum",   {16'h0, bus.flo_sum},  32'h0);
        check("rst.overflow",  {29'h0, bus.overflow}, 32'h0);
        check("rst.out_valid", {31'h0, bus.out_valid}, 32'h0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;

        apply(16'h001B, 16'h002A);
        check("first.fix_sum",   {16'h0, bus.fix_sum},  32'h0045);
        check("first.fix_prod",  {16'h0, bus.fix_prod}, 32'h0004);
        check("first.flo_sum",   {16'h0, bus.flo_sum},  32'h0000);
        check("first.overflow",  {29'h0, bus.overflow}, 32'h0);
        check("first.out_valid", {31'h0, bus.out_valid}, 32'h1);

        foreach (vecs[i]) begin
            apply(vecs[i].n1, vecs[i].n2);
            case (vecs[i].sel)
                0:       act = bus.fix_sum;
                1:       act = bus.fix_prod;
                2:       act = bus.flo_sum;
                default: act = {15'h0, bus.overflow[vecs[i].sel - 3]};
            endcase
            check(vecs[i].name, {16'h0, act}, {16'h0, vecs[i].want});
        end

        // Handshake: three back-to-back pairs then two idle cycles.
        hs_a = '{16'h3C00, 16'h0280, 16'h4A00};
        hs_b = '{16'h4000, 16'hFF40, 16'hC500};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.num1 = hs_a[i]; bus.num2 = hs_b[i];
            @(posedge clk); #1;
            check($sformatf("hs%0d.out_valid", i), {31'h0, bus.out_valid}, 32'h1);
            check_all($sformatf("hs%0d", i), model(hs_a[i], hs_b[i]));
        end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.num1 = 16'hFFFF; bus.num2 = 16'h7777;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check($sformatf("idle%0d.out_valid", i), {31'h0, bus.out_valid}, 32'h0);
            check_all($sformatf("idle%0d", i), model(hs_a[2], hs_b[2]));
        end

        // Reset pulsed mid-burst clears outputs without a clock edge.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.num1 = 16'h0300; bus.num2 = 16'h0200;
        @(posedge clk); #1;
        check("burst.out_valid", {31'h0, bus.out_valid}, 32'h1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst.out_valid", {31'h0, bus.out_valid}, 32'h0);
        check_all("midrst", '{16'h0, 16'h0, 16'h0, 3'h0});
        @(negedge clk);
        rst_n = 1'b1;
        bus.num1 = 16'h0180; bus.num2 = 16'hFF00;
        @(posedge clk); #1;
        check("postrst.out_valid", {31'h0, bus.out_valid}, 32'h1);
        check_all("postrst", model(16'h0180, 16'hFF00));

        // Randomized: sparse valid, outputs must hold between accepted pairs.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            v = (i == 0) || ($urandom_range(3) != 0);
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(1) == 1) b = {~a[15], a[14:0]} ^ 16'($urandom_range(63));
            bus.in_valid = v; bus.num1 = a; bus.num2 = b;
            @(posedge clk); #1;
            if (v) ex = model(a, b);
            check($sformatf("rnd%0d.out_valid", i), {31'h0, bus.out_valid}, {31'h0, v});
            check_all($sformatf("rnd%0d", i), ex);
        end
        bus.in_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
